calculate_1_issue: RTL and testbench



---
 rtl/calculate_1_issue.sv | 163 ++++++++++++++++
 tb/tb_calculate_1_issue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculate_1_issue.sv
// Issue/collect stage for the calculate_1 core: holds operands for the core,
// runs the ap_start/ap_ready/ap_done handshake and queues tagged results.
module calculate_1_issue #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              core_start,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic              core_ready,
    input  logic              core_done,
    input  logic              core_idle,
    input  logic [DATA_W-1:0] core_return,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy,
    output logic              err_timeout,
    output logic [15:0]       op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [DATA_W-1:0]   a_q, b_q;
    logic                err_q;
    logic [15:0]         op_q;

    logic [DATA_W-1:0]   data_q [DEPTH];
    logic                errf_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                accept, push, push_err, pop;
    logic [DATA_W-1:0]   push_data;

    // Accepting only with a free slot guarantees the eventual push cannot overflow.
    assign in_ready = ~ap_rst & (state_q == S_IDLE) & core_idle & (count_q < FULL);
    assign accept   = in_valid & in_ready;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = data_q[rd_ptr_q];
    assign out_err   = errf_q[rd_ptr_q];

    assign core_a      = a_q;
    assign core_b      = b_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;
    assign op_count    = op_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        wd_d       = wd_q;
        push       = 1'b0;
        push_err   = 1'b0;
        push_data  = '0;
        core_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    wd_d    = '0;
                end
            end
            S_START: begin
                core_start = 1'b1;
                wd_d       = wd_q + 1'b1;
                if (core_ready && core_done) begin
                    push      = 1'b1;
                    push_data = core_return;
                    state_d   = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    state_d  = S_DRAIN;
                end else if (core_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                // A done arriving on the last watchdog cycle still counts as a good result.
                if (core_done) begin
                    push      = 1'b1;
                    push_data = core_return;
                    state_d   = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (core_idle) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            if (push && push_err) err_q <= 1'b1;
            if (push) op_q <= op_q + 16'd1;
        end
    end

    // NOTE: the FIFO storage is reset because the head drives out_data/out_err directly.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                errf_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= push_data;
                errf_q[wr_ptr_q] <= push_err;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_calculate_1_issue.sv
// Directed-sequence bench for calculate_1_issue with a behavioural core model
// and a result scoreboard (expected result = a+b, or an error entry on timeout).
module tb_calculate_1_issue;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int TO    = 16;

    logic          ap_clk, ap_rst;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_a, in_b;
    logic          core_start, core_ready, core_done, core_idle;
    logic [DW-1:0] core_a, core_b, core_return;
    logic          out_valid, out_ready, out_err, busy, err_timeout;
    logic [DW-1:0] out_data;
    logic [15:0]   op_count;

    calculate_1_issue #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
        .core_return(core_return),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy), .err_timeout(err_timeout), .op_count(op_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: ap_ready in the first start cycle, ap_done 'lat' cycles later
    // (lat=0 gives ready and done together); 'never' suppresses done entirely.
    int            lat = 3;
    bit            never = 0, abort = 0, inj_done = 0;
    logic [DW-1:0] inj_val = '0;
    logic          m_active = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] m_a = '0, m_b = '0;
    logic          first, normal_done;

    assign first       = core_start & ~m_active;
    assign normal_done = !never && ((first && lat == 0) || (m_active && m_cnt == lat));
    assign core_ready  = first;
    assign core_done   = normal_done | inj_done;
    assign core_return = inj_done ? inj_val : (first ? core_a + core_b : m_a + m_b);
    assign core_idle   = ~m_active;

    always @(posedge ap_clk) begin
        if (ap_rst) begin
            m_active <= 1'b0;
        end else if (m_active) begin
            if (normal_done || abort) m_active <= 1'b0;
            else m_cnt <= m_cnt + 1;
        end else if (first && !normal_done) begin
            m_active <= 1'b1;
            m_cnt    <= 1;
            m_a      <= core_a;
            m_b      <= core_b;
        end
    end

    // Scoreboard: record accepted ops, compare every popped result in order.
    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } res_t;
    res_t exp_q[$];
    int   acc_cyc[$];
    int   cyc = 0;
    bit   cur_to = 0;

    always @(negedge ap_clk) begin
        #1;
        cyc++;
        if (!ap_rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_to ? res_t'({1'b1, {DW{1'b0}}}) : res_t'({1'b0, DW'(in_a + in_b)}));
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("out_data", {32'd0, out_data}, {32'd0, e.data});
                    check("out_err", {63'd0, out_err}, {63'd0, e.err});
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge ap_clk);
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int t = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        check("issue_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin
            tick();
            t++;
        end
        check("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_drain();
        int t = 0;
        out_ready = 1'b1;
        while ((out_valid || exp_q.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({pfx, "_core_start"}, {63'd0, core_start}, 64'd0);
        check({pfx, "_core_ab"}, {core_a, core_b}, 64'd0);
        check({pfx, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({pfx, "_out_data"}, {32'd0, out_data}, 64'd0);
        check({pfx, "_out_err"}, {63'd0, out_err}, 64'd0);
        check({pfx, "_busy"}, {63'd0, busy}, 64'd0);
        check({pfx, "_err_timeout"}, {63'd0, err_timeout}, 64'd0);
        check({pfx, "_op_count"}, {48'd0, op_count}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "time limit reached");
    end

    initial begin
        int k;
        logic [DW-1:0] ra, rb;

        ap_rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        tick(2);
        check_all_zero("reset");
        ap_rst = 1'b0;
        tick();
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Single op: 5 + 7 with a 3-cycle core
        lat = 3;
        issue(32'd5, 32'd7);
        check("start_core_start", {63'd0, core_start}, 64'd1);
        check("start_in_ready", {63'd0, in_ready}, 64'd0);
        k = 0;
        while (busy && k < 50) begin
            check("operands_held", {core_a, core_b}, {32'd5, 32'd7});
            tick();
            k++;
        end
        check("single_out_valid", {63'd0, out_valid}, 64'd1);
        check("single_out_data", {32'd0, out_data}, 64'd12);
        check("single_out_err", {63'd0, out_err}, 64'd0);
        check("single_op_count", {48'd0, op_count}, 64'd1);
        wait_drain();

        // Back-pressure: FIFO fills after two results, third op waits for a pop
        out_ready = 1'b0;
        lat = $urandom_range(1, 4);
        issue($urandom, $urandom);
        issue($urandom, $urandom);
        wait_idle();
        ra = $urandom; rb = $urandom;
        in_a = ra; in_b = rb; in_valid = 1'b1;
        tick(4);
        check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        issue(ra, rb);
        wait_idle();
        wait_drain();
        check("bp_op_count", {48'd0, op_count}, 64'd4);

        // Same-cycle ready/done: sustained two-cycle issue interval
        lat = 0;
        acc_cyc.delete();
        for (int i = 0; i < 8; i++) issue($urandom, $urandom);
        wait_idle();
        wait_drain();
        for (int i = 1; i < 8; i++)
            check("issue_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd2);
        check("fast_op_count", {48'd0, op_count}, 64'd12);

        // Done on the last watchdog cycle wins over the timeout
        lat = TO - 1;
        issue($urandom, $urandom);
        wait_idle();
        wait_drain();
        check("race_err_timeout", {63'd0, err_timeout}, 64'd0);
        check("race_op_count", {48'd0, op_count}, 64'd13);

        // Timeout: core never finishes; late done in DRAIN is dropped
        out_ready = 1'b0;
        never = 1;
        cur_to = 1;
        issue($urandom, $urandom);
        cur_to = 0;
        k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
        check("timeout_latency", 64'(k), 64'(TO));
        check("timeout_out_err", {63'd0, out_err}, 64'd1);
        check("timeout_out_data", {32'd0, out_data}, 64'd0);
        check("timeout_err_flag", {63'd0, err_timeout}, 64'd1);
        check("drain_busy", {63'd0, busy}, 64'd1);
        check("drain_core_start", {63'd0, core_start}, 64'd0);
        inj_val = 32'hDEAD;
        inj_done = 1;
        tick();
        inj_done = 0;
        tick(2);
        abort = 1;
        tick();
        abort = 0;
        wait_idle();
        never = 0;
        check("timeout_op_count", {48'd0, op_count}, 64'd14);
        out_ready = 1'b1;
        tick(3);
        check("late_done_dropped", {63'd0, out_valid}, 64'd0);
        lat = 2;
        issue($urandom, $urandom);
        wait_idle();
        wait_drain();
        check("recover_op_count", {48'd0, op_count}, 64'd15);
        check("err_timeout_sticky", {63'd0, err_timeout}, 64'd1);

        // Reset mid-op with one result held in the FIFO
        out_ready = 1'b0;
        lat = 2;
        issue($urandom, $urandom);
        wait_idle();
        lat = 10;
        issue($urandom, $urandom);
        tick(3);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        check("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
        ap_rst = 1'b1;
        tick();
        check_all_zero("midreset");
        exp_q.delete();
        ap_rst = 1'b0;
        tick();
        check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        lat = 1;
        issue($urandom, $urandom);
        wait_idle();
        wait_drain();
        check("post_reset_op_count", {48'd0, op_count}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
